// File: rtl/sound_channel_core.sv
// ---------------------------------------------------------------------------
// sound_channel_core
// Pulse-wave tone generator for one sound channel. The waveform is divided
// into 8 equal steps of P clock cycles each. The output is high during steps
// 0..width and low during the remaining steps. The amplitude is volume x 65536.
//
// Ports
//   clk     : system clock; all state updates on its rising edge
//   reset   : asynchronous, active-high; clears counters and sample at once
//   period  : [15:0] clk cycles per step (0 is treated as 1), sampled each clk
//   volume  : [4:0]  amplitude 0..31, sampled each clk
//   width   : [2:0]  duty; output is high for (width+1) of the 8 steps
//   sample  : [23:0] registered two's-complement sample, +/-(volume x 65536)
// ---------------------------------------------------------------------------
module sound_channel_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] period,
  input  logic [4:0]  volume,
  input  logic [2:0]  width,
  output logic [23:0] sample
);

  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic [23:0] sample_q, sample_d;

  logic [15:0] p_last_s;   // last cycle index of a step, P-1
  logic        step_end_s;
  logic        high_s;
  logic [23:0] mag_s;

  // Step timing: a >= compare makes a period that shrinks mid-step end the
  // step on the next clock, and lets a longer period stretch the current step.
  always_comb begin
    p_last_s   = 16'd0;
    step_end_s = 1'b0;
    cnt_d      = cnt_q;
    step_d     = step_q;
    if (period == 16'd0) begin
      p_last_s = 16'd0;
    end else begin
      p_last_s = period - 16'd1;
    end
    if (cnt_q >= p_last_s) begin
      step_end_s = 1'b1;
      cnt_d      = 16'd0;
      step_d     = step_q + 3'd1;  // wraps 7 -> 0
    end else begin
      step_end_s = 1'b0;
      cnt_d      = cnt_q + 16'd1;
      step_d     = step_q;
    end
  end

  // Sample value from the pre-edge step, width and volume.
  always_comb begin
    high_s   = 1'b0;
    mag_s    = {3'd0, volume, 16'd0};
    sample_d = 24'd0;
    if (step_q <= width) begin
      high_s   = 1'b1;
      sample_d = mag_s;
    end else begin
      high_s   = 1'b0;
      sample_d = 24'd0 - mag_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 16'd0;
      step_q   <= 3'd0;
      sample_q <= 24'd0;
    end else begin
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      sample_q <= sample_d;
    end
  end

  assign sample = sample_q;

endmodule

// File: tb/tb_sound_channel_core.sv
// ---------------------------------------------------------------------------
// tb_sound_channel_core
// Directed bench for sound_channel_core. A reference model of the step/cycle
// counters pushes the expected sample into a queue before each clock edge. The
// entry is popped and compared 1 time unit after the edge. Directed checks
// against literal waveform patterns run alongside the scoreboard.
// ---------------------------------------------------------------------------
module tb_sound_channel_core;

  logic        clk;
  logic        reset;
  logic [15:0] period;
  logic [4:0]  volume;
  logic [2:0]  width;
  logic [23:0] sample;

  int checks;
  int errors;

  logic [23:0] exp_q[$];
  logic [15:0] m_cnt;
  logic [2:0]  m_step;

  sound_channel_core dut (
    .clk    (clk),
    .reset  (reset),
    .period (period),
    .volume (volume),
    .width  (width),
    .sample (sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and record the result.
  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Predict the next sample, advance the model, clock the DUT, then compare.
  task automatic tick();
    logic [15:0] p;
    logic [23:0] mag;
    logic [23:0] expv;
    p    = (period == 16'd0) ? 16'd1 : period;
    mag  = {3'd0, volume, 16'd0};
    expv = (m_step <= width) ? mag : (24'd0 - mag);
    exp_q.push_back(expv);
    if ({16'd0, m_cnt} >= ({16'd0, p} - 32'd1)) begin
      m_cnt  = 16'd0;
      m_step = m_step + 3'd1;
    end else begin
      m_cnt  = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", sample, 24'hxxxxxx);
    end else begin
      check("scoreboard", sample, exp_q.pop_front());
    end
  endtask

  // Hold reset for two edges and release it 1 unit after an edge.
  task automatic do_reset();
    reset = 1'b1;
    m_cnt  = 16'd0;
    m_step = 3'd0;
    #1;
    check("reset_async", sample, 24'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", sample, 24'd0);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    period = 16'd4;
    width  = 3'd3;
    volume = 5'd1;
    m_cnt  = 16'd0;
    m_step = 3'd0;
    @(posedge clk);
    #1;

    // Pattern: period 4, width 3, volume 1 -> 16 high / 16 low.
    do_reset();
    for (int i = 0; i < 64; i++) begin
      tick();
      check("p4_w3_v1", sample, ((i % 32) < 16) ? 24'h010000 : 24'hFF0000);
    end

    // Pattern: period 2, width 0, volume 31 -> 2 high / 14 low.
    period = 16'd2; width = 3'd0; volume = 5'd31;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      tick();
      check("p2_w0_v31", sample, ((i % 16) < 2) ? 24'h1F0000 : 24'hE10000);
    end

    // Pattern: period 0 and period 1 both advance a step every clock.
    period = 16'd0; width = 3'd3; volume = 5'd5;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      check("p0_w3_v5", sample, ((i % 8) < 4) ? 24'h050000 : 24'hFB0000);
    end
    period = 16'd1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      check("p1_w3_v5", sample, ((i % 8) < 4) ? 24'h050000 : 24'hFB0000);
    end

    // Width 7 is a constant high level; volume 0 gives zero on the next clock.
    period = 16'd37; width = 3'd7; volume = 5'd10;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      check("w7_v10", sample, 24'h0A0000);
    end
    volume = 5'd0;
    tick();
    check("v0_high", sample, 24'd0);
    width = 3'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("v0_any_phase", sample, 24'd0);
    end

    // A period increase mid-step stretches the current step from 4 to 8 cycles.
    period = 16'd4; width = 3'd0; volume = 5'd2;
    do_reset();
    tick(); tick();
    period = 16'd8;
    for (int i = 2; i < 12; i++) begin
      tick();
      check("period_grow", sample, (i < 8) ? 24'h020000 : 24'hFE0000);
    end

    // A period shrink at cnt=600 ends the step on the next clock.
    period = 16'd1000; width = 3'd0; volume = 5'd1;
    do_reset();
    for (int i = 0; i < 1400; i++) begin
      if (i == 600) period = 16'd100;
      tick();
      if (i == 600 || i == 601 || i == 1300 || i == 1301) begin
        check("period_shrink", sample,
              (i <= 600 || i >= 1301) ? 24'h010000 : 24'hFF0000);
      end
    end

    // Reset mid-waveform: zero at once, and a full-length first step after release.
    period = 16'd4; width = 3'd3; volume = 5'd1;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    #2;
    reset = 1'b1;
    m_cnt  = 16'd0;
    m_step = 3'd0;
    #1;
    check("mid_reset_async", sample, 24'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mid_reset_hold", sample, 24'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("after_reset", sample, ((i % 32) < 16) ? 24'h010000 : 24'hFF0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_channel_core.md
SOUND_CHANNEL_CORE -- requirements
Module: sound_channel

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 period  input  16  unsigned clk cycles per waveform step (1/8 of the waveform); sampled every cycle.
REQ-005 volume  input  5  unsigned amplitude, 0..31; sampled every cycle.
REQ-006 width  input  3  duty control: waveform is high for (width+1) of the 8 steps.
REQ-007 sample  output  24  registered two's-complement pulse-wave sample.

Function
REQ-008 SHALL hold a 16-bit cycle counter (cnt) and a 3-bit step counter (step).
REQ-009 Effective period P SHALL be period; if period is 0, P SHALL be 1.
REQ-010 Each clk: if cnt >= P-1, cnt SHALL become 0 and step SHALL increment modulo 8 (7 wraps to 0); otherwise cnt SHALL increment by 1.
REQ-011 The >= compare SHALL apply when period shrinks mid-step: a step already at or past the new P-1 ends on the next clock; no 65536-cycle wrap.
REQ-012 A period increase SHALL lengthen the current step; it takes effect without restarting the waveform.
REQ-013 Phase high SHALL mean step <= width; width=7 gives a constant high level.
REQ-014 Each clk, sample SHALL register +(volume x 65536) when high and -(volume x 65536) when low, from pre-edge step, width and volume.
REQ-015 Latency: sample SHALL reflect a step, width or volume change exactly 1 clk after the change.
REQ-016 volume=0 SHALL give sample = 0 in both phases.
REQ-017 Magnitude SHALL never exceed 31 x 65536 = 2031616 (0x1F0000), so the sum of four channels fits in 24 signed bits without overflow.
REQ-018 Waveform frequency SHALL be f_clk / (8 x P); P=14205 at 50 MHz gives 440 Hz.
REQ-019 Inputs SHALL be assumed synchronous to clk; no internal input synchronisers.

Reset
REQ-020 While reset is high: cnt=0, step=0, sample=0, independent of clk.
REQ-021 On the first rising clk edge after reset deasserts, sample SHALL take the step-0 value (high level for any width).
REQ-022 Reset asserted mid-step or mid-period SHALL abort the waveform; after release, timing SHALL restart from step 0, cnt 0.

Verification
REQ-023 Reset, then period=4, width=3, volume=1: sample = +65536 (0x010000) for 16 clks, then -65536 (0xFF0000) for 16 clks; repeats every 32 clks.
REQ-024 period=2, width=0, volume=31: +2031616 for 2 clks, then -2031616 (0xE10000) for 14 clks; 16-clk cycle.
REQ-025 period=0 and period=1, width=3, volume=5: step advances every clk; sample alternates 4 clks +327680 / 4 clks -327680.
REQ-026 width=7, volume=10, any period: sample constant +655360; volume=0 then gives 0 on the next clk.
REQ-027 period=1000, mid-step at cnt=600 change period to 100: step advances on the next clk (no wrap); later steps last 100 clks.
REQ-028 Assert reset mid-waveform for 3 clks: sample = 0 immediately (asynchronous); after release, waveform restarts at step 0 with full-length first step.
